pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid buffer. It succeeds the fixed 32-bit write-enabled register: it adds configurable width and reset value, backpressure, and a registered ready path. The processor pipeline uses it between stages (F/D, D/X, X/M, M/W) so that stalls and branch flushes are handled by the stage itself rather than by per-bit enable logic.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/en_reg_n.sv | 25 ++
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: handshake FSM states and default payload width.
package pipe_pkg;

    localparam int PIPE_DW = 32;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/en_reg_n.sv
// Load-enabled register with synchronous reset to a parameterised value.
module en_reg_n #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (srst_i) begin
            data_q <= RESET_VALUE;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and synchronous flush.
// Define PIPE_SKID_EN for a skid buffer and a registered in_ready; otherwise in_ready is combinational.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = PIPE_DW,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic             clr;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_load;
    logic [WIDTH-1:0] main_d;

    // Reset and flush have the same effect on every piece of state.
    assign clr       = reset | flush;
    assign out_valid = (state_q != PIPE_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_SKID_EN
    logic             skid_load;
    logic             main_from_skid;
    logic             in_ready_q;
    logic [WIDTH-1:0] skid_q;

    en_reg_n #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
        .clk    (clk),
        .srst_i (clr),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    // in_ready comes straight from a flop so out_ready never reaches upstream combinationally.
    always_ff @(posedge clk) begin
        if (clr) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != PIPE_SKID);
        end
    end

    assign in_ready = in_ready_q;
    assign main_d   = main_from_skid ? skid_q : in_data;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_d   = PIPE_FULL;
                end
            end
            PIPE_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_d   = PIPE_SKID;
                end else if (out_xfer) begin
                    state_d = PIPE_EMPTY;
                end
            end
            PIPE_SKID: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = PIPE_FULL;
                end
            end
            default: begin
                state_d = PIPE_EMPTY;
            end
        endcase
    end
`else
    assign in_ready = ~out_valid | out_ready;
    assign main_d   = in_data;

    // With a combinational in_ready, an input transfer while FULL always coincides with an output transfer.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_d   = PIPE_FULL;
                end
            end
            PIPE_FULL: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = PIPE_EMPTY;
                end
            end
            default: begin
                state_d = PIPE_EMPTY;
            end
        endcase
    end
`endif

    en_reg_n #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_reg (
        .clk    (clk),
        .srst_i (clr),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; builds with or without PIPE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        in_ready_rv;
    logic [31:0] out_data_rv;
    logic        out_valid_rv;

    int          checks;
    int          errors;
    int          n_out;
    int          n_mark;
    logic        acc;
    logic [31:0] sb[$];

    pipe_stage_reg #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    pipe_stage_reg #(
        .WIDTH       (32),
        .RESET_VALUE (32'hFFFF_0000)
    ) u_dut_rv (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_rv),
        .out_data  (out_data_rv),
        .out_valid (out_valid_rv),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs already set; samples before the rising edge,
    // updates the scoreboard for that edge and returns at the next falling edge.
    task automatic cycle();
        logic in_x;
        logic out_x;
        #2;
        in_x  = in_valid && in_ready;
        out_x = out_valid && out_ready;
        check_eq("out_valid", out_valid, sb.size() != 0);
        check_eq("out_valid_rv", out_valid_rv, sb.size() != 0);
`ifdef PIPE_SKID_EN
        check_eq("in_ready", in_ready, sb.size() < 2);
        check_eq("in_ready_rv", in_ready_rv, sb.size() < 2);
`else
        check_eq("in_ready", in_ready, (sb.size() == 0) || out_ready);
        check_eq("in_ready_rv", in_ready_rv, (sb.size() == 0) || out_ready);
`endif
        if (out_valid && sb.size() != 0) begin
            check_eq("out_data", out_data, sb[0]);
        end
        acc = 1'b0;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_x && sb.size() != 0) begin
                $display("out  data=%h", sb[0]);
                void'(sb.pop_front());
                n_out++;
            end
            if (in_x) begin
                $display("in   data=%h", in_data);
                sb.push_back(in_data);
                acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] data);
        int n;
        in_valid = 1'b1;
        in_data  = data;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 20) begin
            cycle();
            n++;
        end
        check_eq("send_accepted", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n_out     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a payload offered.
        repeat (2) cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 32'h0000_0000);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_data_rv", out_data_rv, 32'hFFFF_0000);
        cycle();

        // Streaming back-to-back.
        out_ready = 1'b1;
        n_mark    = n_out;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            cycle();
            check_eq("stream_accept", acc, 1'b1);
        end
        in_valid = 1'b0;
        cycle();
        #1;
        check_eq("stream_count", n_out - n_mark, 4);
        check_eq("drain_keeps_data", out_data, 32'h4);
        cycle();

        // Stall behaviour.
        out_ready = 1'b0;
        n_mark    = n_out;
`ifdef PIPE_SKID_EN
        send(32'hA);
        send(32'hB);
        in_valid = 1'b1;
        in_data  = 32'hC;
        #1;
        check_eq("stall_in_ready", in_ready, 1'b0);
        check_eq("stall_out_data", out_data, 32'hA);
        cycle();
        out_ready = 1'b1;
        send(32'hC);
        cycle();
        #1;
        check_eq("stall_count", n_out - n_mark, 3);
`else
        send(32'hA);
        in_valid = 1'b1;
        in_data  = 32'hB;
        #1;
        check_eq("stall_in_ready", in_ready, 1'b0);
        cycle();
        out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", in_ready, 1'b1);
        send(32'hB);
        cycle();
        #1;
        check_eq("stall_count", n_out - n_mark, 2);
`endif
        cycle();

        // Flush while holding data, with a payload offered in the flush cycle.
        out_ready = 1'b0;
        n_mark    = n_out;
        send(32'h5);
`ifdef PIPE_SKID_EN
        send(32'h6);
`endif
        in_valid = 1'b1;
        in_data  = 32'h7;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) cycle();
        check_eq("flush_nothing_out", n_out - n_mark, 0);

        // Reset and flush together while FULL.
        out_ready = 1'b0;
        send(32'h9);
        reset = 1'b1;
        flush = 1'b1;
        cycle();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("rp_out_valid", out_valid, 1'b0);
        check_eq("rp_out_data", out_data, 32'h0000_0000);
        check_eq("rp_out_data_rv", out_data_rv, 32'hFFFF_0000);
        check_eq("rp_in_ready", in_ready, 1'b1);
        cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        #1;
        check_eq("final_drained", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
